// File: rtl/ptr_sync_pkg.sv
// Shared helpers for the multi-channel Gray pointer synchronizer.
// Functions take a width argument and operate on zero-extended words.
package ptr_sync_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int NUM_CH_MIN      = 1;
    localparam int NUM_CH_MAX      = 8;
    localparam int FN_W            = 32;

    typedef logic [FN_W-1:0] word_t;

    function automatic word_t width_mask(input int w);
        word_t m;
        m = '0;
        for (int i = 0; i < FN_W; i++) begin
            if (i < w) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Prefix XOR from the MSB down; zero-extension keeps it width independent.
    function automatic word_t gray2bin(input word_t g, input int w);
        word_t b;
        b = g & width_mask(w);
        for (int s = 1; s < FN_W; s = s * 2) begin
            b = b ^ (b >> s);
        end
        return b & width_mask(w);
    endfunction

    function automatic word_t bin2gray(input word_t b, input int w);
        word_t v;
        v = b & width_mask(w);
        return v ^ (v >> 1);
    endfunction

    function automatic int popcount(input word_t v, input int w);
        int n;
        n = 0;
        for (int i = 0; i < FN_W; i++) begin
            if (i < w) n = n + int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/ptr_sync_multi_chain.sv
// One channel's metastability flop chain; every stage is marked ASYNC_REG
// so placement keeps the stages adjacent.
module sync_chain
    import ptr_sync_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int STAGES = SYNC_STAGES_MIN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                stage[k] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int k = 1; k < STAGES; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/ptr_sync_multi.sv
// Multi-channel Gray pointer synchronizer into the read clock domain.
// Optional multi-bit-jump checking is enabled by defining SYNC_ERR_CHECK_EN.
module ptr_sync_multi
    import ptr_sync_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int NUM_CH      = 1
) (
    input  logic                             rclk,
    input  logic                             rrst_n,
    input  logic [NUM_CH*(ADDR_WIDTH+1)-1:0] gray_in,
    output logic [NUM_CH*(ADDR_WIDTH+1)-1:0] gray_sync,
    output logic [NUM_CH*(ADDR_WIDTH+1)-1:0] bin_sync,
    output logic [NUM_CH*(ADDR_WIDTH+1)-1:0] ptr_delta,
    output logic [NUM_CH-1:0]                ptr_chg,
    output logic                             sync_ready,
    output logic [NUM_CH-1:0]                gray_err,
    input  logic [NUM_CH-1:0]                err_clr
);

    localparam int PW     = ADDR_WIDTH + 1;
    localparam int CNT_W  = $clog2(SYNC_STAGES + 2);
    localparam int WARM_N = SYNC_STAGES + 1;

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("ptr_sync_multi: SYNC_STAGES must be within 2..4");
    end
    if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_bad_ch
        $error("ptr_sync_multi: NUM_CH must be within 1..8");
    end

    // Warm-up: ready once the first post-reset sample has crossed the chain.
    logic [CNT_W-1:0] warm_cnt_p1;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            warm_cnt_p1 <= '0;
        end else if (warm_cnt_p1 != CNT_W'(WARM_N)) begin
            warm_cnt_p1 <= warm_cnt_p1 + CNT_W'(1);
        end
    end

    assign sync_ready = (warm_cnt_p1 == CNT_W'(WARM_N));

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [PW-1:0] gray_p0;
        logic [PW-1:0] bin_p0;
        logic [PW-1:0] gray_p1;
        logic [PW-1:0] bin_p1;
        logic [PW-1:0] delta_p1;
        logic          chg_p1;

        sync_chain #(
            .WIDTH  (PW),
            .STAGES (SYNC_STAGES)
        ) u_chain (
            .clk   (rclk),
            .rst_n (rrst_n),
            .d     (gray_in[c*PW +: PW]),
            .q     (gray_p0)
        );

        assign bin_p0 = PW'(gray2bin(word_t'(gray_p0), PW));

        // Output stage: delta is only recaptured on an actual pointer move.
        always_ff @(posedge rclk or negedge rrst_n) begin
            if (!rrst_n) begin
                gray_p1  <= '0;
                bin_p1   <= '0;
                delta_p1 <= '0;
                chg_p1   <= 1'b0;
            end else begin
                gray_p1 <= gray_p0;
                bin_p1  <= bin_p0;
                chg_p1  <= (gray_p0 != gray_p1);
                if (gray_p0 != gray_p1) begin
                    delta_p1 <= bin_p0 - bin_p1;
                end
            end
        end

        assign gray_sync[c*PW +: PW] = gray_p1;
        assign bin_sync[c*PW +: PW]  = bin_p1;
        assign ptr_delta[c*PW +: PW] = delta_p1;
        assign ptr_chg[c]            = chg_p1;

`ifdef SYNC_ERR_CHECK_EN
        logic err_p1;

        always_ff @(posedge rclk or negedge rrst_n) begin
            if (!rrst_n) begin
                err_p1 <= 1'b0;
            end else if (sync_ready && (popcount(word_t'(gray_p0 ^ gray_p1), PW) > 1)) begin
                err_p1 <= 1'b1;
            end else if (err_clr[c]) begin
                err_p1 <= 1'b0;
            end
        end

        assign gray_err[c] = err_p1;
`else
        assign gray_err[c] = 1'b0;
`endif
    end

`ifndef SYNC_ERR_CHECK_EN
    logic unused_err_clr;
    assign unused_err_clr = ^err_clr;
`endif

endmodule
